regfile_writer: RTL and testbench
=================================

REGFILE_WRITER -- requirements
Module: regfile_writer

Parameters
REQ-001 DATA_WIDTH, default 32, width of write and read data.
REQ-002 SEL_WIDTH, default 5, register address width (32 registers).
REQ-003 DEPTH, default 4, writeback queue entries (power of two, at least 2).

Interface
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wb_valid  input  1  writeback request present.
REQ-007 wb_ready  output  1  request accepted when wb_valid and wb_ready are both high at a rising edge.
REQ-008 wb_addr  input  SEL_WIDTH  destination register.
REQ-009 wb_data  input  DATA_WIDTH  writeback value.
REQ-010 wr_stall  input  1  high: register-file write port unavailable; no write issued this cycle.
REQ-011 RegWrite  output  1  write enable to register file.
REQ-012 write_address  output  SEL_WIDTH  register-file write address.
REQ-013 write_data  output  DATA_WIDTH  register-file write data.
REQ-014 read_sel_1, read_sel_2  input  SEL_WIDTH each  read addresses, also driven to the register file.
REQ-015 rf_read_data_1, rf_read_data_2  input  DATA_WIDTH each  raw register-file read data.
REQ-016 read_data_1, read_data_2  output  DATA_WIDTH each  forwarded read data.
REQ-017 init_done  output  1  high once the clear sequence is complete.
REQ-018 pending  output  clog2(DEPTH+1)  current queue occupancy.

Function
REQ-019 States: INIT and RUN; INIT is entered on reset.
REQ-020 INIT: a SEL_WIDTH-bit counter starts at 0; each non-stalled cycle drives RegWrite=1, write_address=counter, write_data=0, and the counter increments at the edge.
REQ-021 INIT with wr_stall=1: RegWrite=0 and the counter holds.
REQ-022 The edge that writes address 2^SEL_WIDTH-1 moves the state to RUN; init_done=1 from then on.
REQ-023 INIT: wb_ready=0, and read_data_1 and read_data_2 are 0.
REQ-024 RUN: wb_ready = (pending != DEPTH); push when wb_valid && wb_ready.
REQ-025 A push with wb_addr=0 is accepted but discarded: not enqueued and pending unchanged.
REQ-026 RUN: RegWrite = (pending != 0) && !wr_stall; write_address and write_data come from the head entry.
REQ-027 The head pops at the edge where RegWrite=1.
REQ-028 When RegWrite=0, write_address and write_data are 0.
REQ-029 A push and a pop in the same cycle leave pending unchanged; entries leave in FIFO order.
REQ-030 Head and tail pointers wrap modulo DEPTH.
REQ-031 Full queue: wb_ready=0 even when a pop occurs in the same cycle (no push-through).
REQ-032 Empty queue: a push is not forwarded to the write port in the same cycle; earliest write is the next cycle.
REQ-033 Forwarding, per port x: if read_sel_x != 0 and a queued entry matches, read_data_x is the data of the youngest matching entry; otherwise read_data_x = rf_read_data_x.
REQ-034 Forwarding is combinational and considers the entries held before the current edge, including the head being written this cycle.
REQ-035 pending is always in 0..DEPTH; the queue never overflows or underflows.

Reset
REQ-036 rst_n low immediately forces: state INIT, counter 0, pointers 0, pending 0, RegWrite 0, write_address 0, write_data 0, wb_ready 0, init_done 0.
REQ-037 Reset asserted mid-INIT or mid-RUN discards all queued entries; the clear sequence restarts from address 0 after release.
REQ-038 Queue data storage needs no reset, but no stale entry may be written or forwarded after reset.

Verification
REQ-039 Release reset, wr_stall=0 -> 32 consecutive writes of 0 to addresses 0..31, then init_done=1 and wb_ready=1 on the next cycle.
REQ-040 wr_stall=1 for 3 cycles during INIT at counter=7 -> address 7 written once after the stall; init_done is delayed by 3 cycles.
REQ-041 RUN, wr_stall=1, push (2,FFFFFFFF), (5,EEEEEEEE), (2,12345678), (9,1) -> pending=4 and wb_ready=0; read_sel_1=2 gives 12345678; read_sel_2=5 gives EEEEEEEE; read_sel 7 gives rf data.
REQ-042 Then wr_stall=0 -> writes (2,FFFFFFFF), (5,EEEEEEEE), (2,12345678), (9,1) on 4 consecutive cycles; pending reaches 0.
REQ-043 Push (0,AAAAAAAA) -> accepted, pending unchanged, no write issued; read_sel=0 returns rf_read_data_x.
REQ-044 rst_n pulsed low with 3 entries queued -> outputs go to reset values immediately and no queued entry is ever written; INIT restarts at address 0.

Source files
------------

// File: rtl/regfile_writer.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writer
// Brief   : Register-file clear sequencer plus writeback queue with read
//           forwarding of queued (not yet written) results.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [SEL_WIDTH-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0]        wb_data,

    input  logic                         wr_stall,
    output logic                         RegWrite,
    output logic [SEL_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]        write_data,

    input  logic [SEL_WIDTH-1:0]         read_sel_1,
    input  logic [SEL_WIDTH-1:0]         read_sel_2,
    input  logic [DATA_WIDTH-1:0]        rf_read_data_1,
    input  logic [DATA_WIDTH-1:0]        rf_read_data_2,
    output logic [DATA_WIDTH-1:0]        read_data_1,
    output logic [DATA_WIDTH-1:0]        read_data_2,

    output logic                         init_done,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]             r_state;
    logic [SEL_WIDTH-1:0]   r_clr_cnt;
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [c_CNT_W-1:0]     r_count;

    logic [SEL_WIDTH-1:0]   r_q_addr [DEPTH];
    logic [DATA_WIDTH-1:0]  r_q_data [DEPTH];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                   w_init;
    logic                   w_run;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_we;
    logic                   w_pop;
    logic                   w_clr_last;

    // rst_n gates the outputs so they fall the moment reset is asserted
    assign w_init     = rst_n && (r_state == c_ST_INIT);
    assign w_run      = rst_n && (r_state == c_ST_RUN);
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_clr_last = (r_clr_cnt == {SEL_WIDTH{1'b1}});

    assign wb_ready   = w_run && !w_full;
    assign w_push     = wb_valid && wb_ready && (wb_addr != '0);
    assign w_we       = !wr_stall && (w_init || (w_run && !w_empty));
    assign w_pop      = w_run && w_we;

    assign init_done  = w_run;
    assign pending    = r_count;

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    always_comb begin
        RegWrite      = w_we;
        write_address = '0;
        write_data    = '0;
        if (w_we) begin
            if (w_init) begin
                write_address = r_clr_cnt;
            end else begin
                write_address = r_q_addr[r_head];
                write_data    = r_q_data[r_head];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing: clear counter, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_INIT;
            r_clr_cnt <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    if (!wr_stall) begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                        if (w_clr_last) begin
                            r_state <= c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (w_push) begin
                        r_tail <= r_tail + 1'b1;
                    end
                    if (w_pop) begin
                        r_head <= r_head + 1'b1;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
                default: begin
                    r_state <= c_ST_INIT;
                end
            endcase
        end
    end

    // Payload storage is unreset; r_count alone decides which slots are live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_tail] <= wb_addr;
            r_q_data[r_tail] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: slot gi holds the gi-th oldest entry
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]     w_slot_idx  [DEPTH];
    logic [DEPTH-1:0]       w_slot_live;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign w_slot_idx[gi]  = r_head + c_PTR_W'(gi);
        assign w_slot_live[gi] = (c_CNT_W'(gi) < r_count);
    end

    logic                   w_hit_1;
    logic                   w_hit_2;
    logic [DATA_WIDTH-1:0]  w_fwd_1;
    logic [DATA_WIDTH-1:0]  w_fwd_2;

    // Scan oldest to youngest so the youngest match is the one that sticks
    always_comb begin
        w_hit_1 = 1'b0;
        w_hit_2 = 1'b0;
        w_fwd_1 = '0;
        w_fwd_2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_live[i] && (r_q_addr[w_slot_idx[i]] == read_sel_1)) begin
                w_hit_1 = 1'b1;
                w_fwd_1 = r_q_data[w_slot_idx[i]];
            end
            if (w_slot_live[i] && (r_q_addr[w_slot_idx[i]] == read_sel_2)) begin
                w_hit_2 = 1'b1;
                w_fwd_2 = r_q_data[w_slot_idx[i]];
            end
        end
    end

    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        if (w_run) begin
            read_data_1 = ((read_sel_1 != '0) && w_hit_1) ? w_fwd_1 : rf_read_data_1;
            read_data_2 = ((read_sel_2 != '0) && w_hit_2) ? w_fwd_2 : rf_read_data_2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_writer
// Brief   : Randomised and directed bench for regfile_writer against a
//           queue-based behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_writer;

    localparam int DW    = 32;
    localparam int SW    = 5;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wb_valid;
    logic           wb_ready;
    logic [SW-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;
    logic           wr_stall;
    logic           RegWrite;
    logic [SW-1:0]  write_address;
    logic [DW-1:0]  write_data;
    logic [SW-1:0]  read_sel_1;
    logic [SW-1:0]  read_sel_2;
    logic [DW-1:0]  rf_read_data_1;
    logic [DW-1:0]  rf_read_data_2;
    logic [DW-1:0]  read_data_1;
    logic [DW-1:0]  read_data_2;
    logic           init_done;
    logic [2:0]     pending;

    always #5 clk = ~clk;

    regfile_writer #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wr_stall       (wr_stall),
        .RegWrite       (RegWrite),
        .write_address  (write_address),
        .write_data     (write_data),
        .read_sel_1     (read_sel_1),
        .read_sel_2     (read_sel_2),
        .rf_read_data_1 (rf_read_data_1),
        .rf_read_data_2 (rf_read_data_2),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2),
        .init_done      (init_done),
        .pending        (pending)
    );

    typedef struct packed {
        logic [SW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model: clear phase flag, clear counter, FIFO of writebacks
    bit     m_run;
    int     m_cnt;
    ent_t   m_q[$];

    int     n_checks = 0;
    int     n_errors = 0;

    logic           obs_we;
    logic [SW-1:0]  obs_addr;
    logic           obs_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_fwd(input logic [SW-1:0] sel, input logic [DW-1:0] rf);
        if (sel == '0) return rf;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].a == sel) return m_q[i].d;
        end
        return rf;
    endfunction

    task automatic step(input logic v, input logic [SW-1:0] a, input logic [DW-1:0] d,
                        input logic st, input logic [SW-1:0] s1, input logic [SW-1:0] s2);
        logic          e_we;
        logic          e_rdy;
        logic [SW-1:0] e_a;
        logic [DW-1:0] e_d;
        ent_t          e;
        @(negedge clk);
        wb_valid       = v;
        wb_addr        = a;
        wb_data        = d;
        wr_stall       = st;
        read_sel_1     = s1;
        read_sel_2     = s2;
        rf_read_data_1 = $urandom;
        rf_read_data_2 = $urandom;
        #2;
        if (!m_run) begin
            e_we  = !st;
            e_a   = e_we ? SW'(m_cnt) : '0;
            e_d   = '0;
            e_rdy = 1'b0;
        end else begin
            e_rdy = (m_q.size() != DEPTH);
            e_we  = (m_q.size() != 0) && !st;
            e_a   = e_we ? m_q[0].a : '0;
            e_d   = e_we ? m_q[0].d : '0;
        end
        check_eq("RegWrite", RegWrite, e_we);
        check_eq("write_address", write_address, e_a);
        check_eq("write_data", write_data, e_d);
        check_eq("wb_ready", wb_ready, e_rdy);
        check_eq("init_done", init_done, m_run);
        check_eq("pending", pending, m_q.size());
        check_eq("read_data_1", read_data_1, m_run ? model_fwd(s1, rf_read_data_1) : '0);
        check_eq("read_data_2", read_data_2, m_run ? model_fwd(s2, rf_read_data_2) : '0);
        obs_we   = RegWrite;
        obs_addr = write_address;
        obs_done = init_done;
        @(posedge clk);
        if (!m_run) begin
            if (!st) begin
                if (m_cnt == (1 << SW) - 1) m_run = 1'b1;
                m_cnt = (m_cnt + 1) % (1 << SW);
            end
        end else begin
            if (e_we) void'(m_q.pop_front());
            if (v && e_rdy && (a != '0)) begin
                e.a = a;
                e.d = d;
                m_q.push_back(e);
            end
        end
    endtask

    // Asserts reset away from any edge and checks outputs fall at once
    task automatic do_reset();
        @(negedge clk);
        wr_stall = 1'b0;
        wb_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_RegWrite", RegWrite, 1'b0);
        check_eq("rst_write_address", write_address, '0);
        check_eq("rst_write_data", write_data, '0);
        check_eq("rst_wb_ready", wb_ready, 1'b0);
        check_eq("rst_init_done", init_done, 1'b0);
        check_eq("rst_pending", pending, '0);
        wr_stall = 1'b1;
        m_run = 1'b0;
        m_cnt = 0;
        m_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs the clear sequence; stalls for n_stall cycles when the counter is 7
    task automatic run_init(input int n_stall, input int exp_len);
        int cyc;
        int n7;
        int stalled;
        bit seen;
        cyc     = 0;
        n7      = 0;
        stalled = 0;
        seen    = 1'b0;
        while (cyc < 200 && !seen) begin
            step(1'b0, '0, '0, (m_cnt == 7 && !m_run && stalled < n_stall), 5'd0, 5'd0);
            if (!m_run && m_cnt == 7 && wr_stall) stalled++;
            if (obs_done) seen = 1'b1;
            else begin
                if (obs_we && obs_addr == 5'd7) n7++;
                cyc++;
            end
        end
        check_eq("init_len", cyc, exp_len);
        check_eq("addr7_writes", n7, 1);
    endtask

    initial begin
        rst_n          = 1'b0;
        wb_valid       = 1'b0;
        wb_addr        = '0;
        wb_data        = '0;
        wr_stall       = 1'b1;
        read_sel_1     = '0;
        read_sel_2     = '0;
        rf_read_data_1 = '0;
        rf_read_data_2 = '0;
        m_run          = 1'b0;
        m_cnt          = 0;

        do_reset();
        run_init(0, 32);

        do_reset();
        run_init(3, 35);

        // Fill four entries while the write port is stalled, then probe forwarding
        step(1'b1, 5'd2, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd5, 32'hEEEE_EEEE, 1'b1, 5'd2, 5'd0);
        step(1'b1, 5'd2, 32'h1234_5678, 1'b1, 5'd2, 5'd5);
        step(1'b1, 5'd9, 32'h0000_0001, 1'b1, 5'd2, 5'd5);
        step(1'b1, 5'd3, 32'h5555_5555, 1'b1, 5'd2, 5'd5);
        check_eq("full_pending", pending, 3'd4);
        check_eq("full_ready", wb_ready, 1'b0);
        step(1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd9);

        // Drain, with a push offered on the first draining cycle while full
        step(1'b1, 5'd4, 32'h4444_4444, 1'b0, 5'd2, 5'd5);
        step(1'b0, 5'd0, '0, 1'b0, 5'd2, 5'd5);
        step(1'b0, 5'd0, '0, 1'b0, 5'd2, 5'd9);
        step(1'b0, 5'd0, '0, 1'b0, 5'd9, 5'd2);
        step(1'b0, 5'd0, '0, 1'b0, 5'd9, 5'd2);
        check_eq("drained_pending", pending, 3'd0);

        // Writes to register 0 are swallowed
        step(1'b1, 5'd0, 32'hAAAA_AAAA, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);

        // Empty-queue push is not written in the same cycle
        step(1'b1, 5'd6, 32'h6666_6666, 1'b0, 5'd6, 5'd0);
        step(1'b0, 5'd0, '0, 1'b0, 5'd6, 5'd0);

        // Reset with entries queued: none may surface afterwards
        step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd8, 32'h8888_8888, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd1, 32'h2222_2222, 1'b1, 5'd1, 5'd8);
        do_reset();
        run_init(0, 32);
        step(1'b0, 5'd0, '0, 1'b0, 5'd1, 5'd8);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
